// File: rtl/spi_sample_sched.sv
// Periodic SPI sensor sampler. It requests a byte every `period` cycles and queues the captured samples in a FIFO.
// Define SPI_SCHED_AVG_EN to push the truncated mean of every four captures instead of each raw byte.
module spi_sample_sched #(
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [PERIOD_W-1:0]         period,
  output logic                        spi_valid,
  input  logic                        spi_ready,
  input  logic [7:0]                  spi_data,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  input  logic                        clr_err,
  output logic                        overflow,
  output logic                        timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, REQUEST, DRAIN} state_t;

  state_t              state, next_state;
  logic [PERIOD_W-1:0] wait_cnt, load_val;
  logic [TO_W-1:0]     to_cnt;
  logic                capture, timeout_hit;
  logic                push_req;
  logic [7:0]          push_data;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                pop, drop, push_ok;

  assign load_val    = (period == '0) ? PERIOD_W'(1) : period;
  assign capture     = (state == REQUEST) && spi_ready;
  assign timeout_hit = (state == REQUEST) && !spi_ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = WAIT;
      WAIT: begin
        if (!enable)                          next_state = IDLE;
        else if (wait_cnt == PERIOD_W'(1))    next_state = REQUEST;
      end
      REQUEST: if (capture || timeout_hit) next_state = DRAIN;
      DRAIN:   if (!spi_ready) next_state = enable ? WAIT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The wait counter keeps tracking the reload value outside WAIT, so entering WAIT always starts a full interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      to_cnt    <= '0;
      spi_valid <= 1'b0;
    end else begin
      wait_cnt  <= (state == WAIT) ? wait_cnt - PERIOD_W'(1) : load_val;
      to_cnt    <= (state == REQUEST) ? to_cnt + TO_W'(1) : '0;
      spi_valid <= (next_state == REQUEST);
    end
  end

`ifdef SPI_SCHED_AVG_EN
  logic [9:0] acc_sum, acc_total;
  logic [1:0] acc_cnt;

  assign acc_total = acc_sum + {2'b00, spi_data};

  // The fourth capture completes a group: its mean is pushed and the partial sum restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_req  <= 1'b0;
      push_data <= '0;
      acc_sum   <= '0;
      acc_cnt   <= '0;
    end else begin
      push_req <= 1'b0;
      if (capture) begin
        if (acc_cnt == 2'd3) begin
          push_req  <= 1'b1;
          push_data <= 8'(acc_total >> 2);
          acc_sum   <= '0;
          acc_cnt   <= '0;
        end else begin
          acc_sum <= acc_total;
          acc_cnt <= acc_cnt + 2'd1;
        end
      end else if ((state == IDLE) && !enable) begin
        acc_sum <= '0;
        acc_cnt <= '0;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= capture;
      if (capture) push_data <= spi_data;
    end
  end
`endif

  // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
  assign pop     = rd_en && (level != '0);
  assign drop    = push_req && (level == DEPTH_L) && !pop;
  assign push_ok = push_req && !drop;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH_L);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky flags: a new error event outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_sample_sched.sv
// Self-checking bench for spi_sample_sched: vector table, hand-written corner sequences and a randomized queue-model run.
// Built with SPI_SCHED_AVG_EN defined, it runs the four-sample averaging sequence instead.
module tb_spi_sample_sched;

  localparam int PERIOD_W   = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 1023;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        enable;
  logic [PERIOD_W-1:0]         period;
  logic                        spi_valid;
  logic                        spi_ready;
  logic [7:0]                  spi_data;
  logic                        rd_en;
  logic [7:0]                  rd_data;
  logic                        empty;
  logic                        full;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                        clr_err;
  logic                        overflow;
  logic                        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_sample_sched #(
    .PERIOD_W(PERIOD_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .period(period),
    .spi_valid(spi_valid),
    .spi_ready(spi_ready),
    .spi_data(spi_data),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .level(level),
    .clr_err(clr_err),
    .overflow(overflow),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic                en;
    logic [PERIOD_W-1:0] per;
    logic                rdy;
    logic [7:0]          dat;
    logic                rd;
    logic                exp_valid;
    int                  exp_level;
    logic [7:0]          exp_rd;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [PERIOD_W-1:0] per, input logic rdy,
                               input logic [7:0] dat, input logic rd, input logic clr);
    enable    = en;
    period    = per;
    spi_ready = rdy;
    spi_data  = dat;
    rd_en     = rd;
    clr_err   = clr;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (spi_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    checkOutput("spi_valid_seen", int'(spi_valid), 1);
  endtask

  task automatic doTransaction(input logic [7:0] d);
    int n;
    waitValid(100, n);
    spi_ready = 1'b1;
    spi_data  = d;
    step();
    spi_ready = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_spi_valid"}, int'(spi_valid), 0);
    checkOutput({tag, "_empty"}, int'(empty), 1);
    checkOutput({tag, "_full"}, int'(full), 0);
    checkOutput({tag, "_level"}, int'(level), 0);
    checkOutput({tag, "_rd_data"}, int'(rd_data), 0);
    checkOutput({tag, "_overflow"}, int'(overflow), 0);
    checkOutput({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

`ifdef SPI_SCHED_AVG_EN
  task automatic runAverage();
    logic [7:0] samples [4];
    samples = '{8'h10, 8'h20, 8'h30, 8'h41};
    doReset();
    applyStimulus(1'b1, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      doTransaction(samples[i]);
      step();
      checkOutput($sformatf("avg_level_after_%0d", i + 1), int'(level), (i == 3) ? 1 : 0);
    end
    enable = 1'b0;
    rd_en  = 1'b1;
    step();
    rd_en  = 1'b0;
    checkOutput("avg_rd_data", int'(rd_data), 8'h28);
    checkOutput("avg_level_after_pop", int'(level), 0);
  endtask
`else
  task automatic runTable();
    vec_t vecs [16];
    vecs[0]  = '{1'b1, 16'd2, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00};
    vecs[1]  = '{1'b1, 16'd2, 1'b0, 8'h00, 1'b0, 1'b0, 0, 8'h00};
    vecs[2]  = '{1'b1, 16'd2, 1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00};
    vecs[3]  = '{1'b1, 16'd2, 1'b1, 8'h5A, 1'b0, 1'b0, 0, 8'h00};
    vecs[4]  = '{1'b1, 16'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h00};
    vecs[5]  = '{1'b1, 16'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h00};
    vecs[6]  = '{1'b1, 16'd2, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h5A};
    vecs[7]  = '{1'b1, 16'd2, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'h5A};
    vecs[8]  = '{1'b0, 16'd2, 1'b1, 8'hC3, 1'b0, 1'b0, 0, 8'h5A};
    vecs[9]  = '{1'b0, 16'd2, 1'b1, 8'hC3, 1'b0, 1'b0, 1, 8'h5A};
    vecs[10] = '{1'b0, 16'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h5A};
    vecs[11] = '{1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h5A};
    vecs[12] = '{1'b1, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1, 8'h5A};
    vecs[13] = '{1'b1, 16'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1, 8'h5A};
    vecs[14] = '{1'b1, 16'd0, 1'b0, 8'h00, 1'b1, 1'b1, 0, 8'hC3};
    vecs[15] = '{1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 8'hC3};
    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].en, vecs[i].per, vecs[i].rdy, vecs[i].dat, vecs[i].rd, 1'b0);
      step();
      checkOutput($sformatf("vec%0d_spi_valid", i), int'(spi_valid), int'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_level", i), int'(level), vecs[i].exp_level);
      checkOutput($sformatf("vec%0d_empty", i), int'(empty), (vecs[i].exp_level == 0) ? 1 : 0);
      checkOutput($sformatf("vec%0d_full", i), int'(full), 0);
      checkOutput($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vecs[i].exp_rd));
    end
  endtask

  task automatic runLatency();
    int periods [4];
    int n;
    int per_eff;
    periods = '{0, 1, 3, 5};
    for (int i = 0; i < 4; i++) begin
      per_eff = (periods[i] == 0) ? 1 : periods[i];
      doReset();
      applyStimulus(1'b1, PERIOD_W'(periods[i]), 1'b0, 8'h00, 1'b0, 1'b0);
      waitValid(100, n);
      checkOutput($sformatf("lat_enable_p%0d", periods[i]), n, per_eff + 1);
      spi_ready = 1'b1;
      spi_data  = 8'hA0;
      step();
      spi_ready = 1'b0;
      waitValid(100, n);
      checkOutput($sformatf("lat_capture_p%0d", periods[i]), n, per_eff + 1);
    end
  endtask

  task automatic runOverflow();
    logic [7:0] drain_exp [8];
    int n;
    drain_exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hA5};
    doReset();
    applyStimulus(1'b1, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) doTransaction(8'(8'h10 + i));
    // Ninth push lands on a full FIFO together with a clear: the drop must win.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checkOutput("ovf_level", int'(level), 8);
    checkOutput("ovf_full", int'(full), 1);
    checkOutput("ovf_flag_set_wins", int'(overflow), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checkOutput("ovf_cleared", int'(overflow), 0);
    checkOutput("ovf_full_after_clr", int'(full), 1);
    waitValid(100, n);
    spi_ready = 1'b1;
    spi_data  = 8'hA5;
    step();
    spi_ready = 1'b0;
    rd_en     = 1'b1;
    enable    = 1'b0;
    step();
    rd_en     = 1'b0;
    checkOutput("fullpop_level", int'(level), 8);
    checkOutput("fullpop_overflow", int'(overflow), 0);
    checkOutput("fullpop_rd_data", int'(rd_data), 8'h10);
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
      checkOutput($sformatf("drain%0d_rd_data", i), int'(rd_data), int'(drain_exp[i]));
    end
    step();
    rd_en = 1'b0;
    checkOutput("empty_pop_rd_data", int'(rd_data), 8'hA5);
    checkOutput("empty_pop_level", int'(level), 0);
    checkOutput("empty_pop_empty", int'(empty), 1);
  endtask

  task automatic runTimeout();
    int n;
    int high_cycles;
    doReset();
    applyStimulus(1'b1, 16'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    waitValid(100, n);
    checkOutput("to_err_before", int'(timeout_err), 0);
    high_cycles = 0;
    while (spi_valid === 1'b1 && high_cycles < TIMEOUT + 100) begin
      high_cycles++;
      step();
    end
    checkOutput("to_valid_cycles", high_cycles, TIMEOUT);
    checkOutput("to_err_set", int'(timeout_err), 1);
    checkOutput("to_level", int'(level), 0);
    checkOutput("to_empty", int'(empty), 1);
    enable  = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checkOutput("to_err_cleared", int'(timeout_err), 0);
  endtask

  task automatic runAsyncReset();
    int n;
    doReset();
    applyStimulus(1'b1, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0);
    doTransaction(8'h77);
    waitValid(100, n);
    step();
    step();
    checkOutput("ar_pre_valid", int'(spi_valid), 1);
    checkOutput("ar_pre_level", int'(level), 1);
    #2;
    rst = 1'b1;
    #1;
    checkReset("ar_async");
    step();
    step();
    rst = 1'b0;
    waitValid(100, n);
    checkOutput("ar_restart_latency", n, 2);
  endtask

  task automatic runRandom();
    logic [7:0] q [$];
    logic [7:0] exp_rd;
    logic       exp_ovf;
    logic       push_pending;
    logic [7:0] pending_data;
    logic       do_pop;
    logic       drop;
    int         hold;
    int         pop_pct;
    exp_rd       = 8'h00;
    exp_ovf      = 1'b0;
    push_pending = 1'b0;
    pending_data = 8'h00;
    hold         = 0;
    pop_pct      = 30;
    doReset();
    applyStimulus(1'b1, 16'd1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checkOutput("rnd_level", int'(level), q.size());
      checkOutput("rnd_empty", int'(empty), (q.size() == 0) ? 1 : 0);
      checkOutput("rnd_full", int'(full), (q.size() == FIFO_DEPTH) ? 1 : 0);
      checkOutput("rnd_overflow", int'(overflow), int'(exp_ovf));
      checkOutput("rnd_timeout_err", int'(timeout_err), 0);
      checkOutput("rnd_rd_data", int'(rd_data), int'(exp_rd));
      if (cyc % 500 == 0) begin
        period  = PERIOD_W'($urandom_range(0, 3));
        pop_pct = (cyc % 1000 == 0) ? 5 : 45;
      end
      if (spi_ready) begin
        if (hold > 0) hold--;
        else spi_ready = 1'b0;
      end else if (spi_valid && $urandom_range(0, 2) == 0) begin
        spi_ready = 1'b1;
        spi_data  = 8'($urandom);
        hold      = int'($urandom_range(0, 1));
      end
      rd_en   = ($urandom_range(0, 99) < pop_pct);
      clr_err = ($urandom_range(0, 19) == 0);
      do_pop = rd_en && (q.size() > 0);
      drop   = push_pending && (q.size() == FIFO_DEPTH) && !do_pop;
      if (do_pop) exp_rd = q.pop_front();
      if (push_pending && !drop) q.push_back(pending_data);
      if (drop) exp_ovf = 1'b1;
      else if (clr_err) exp_ovf = 1'b0;
      push_pending = spi_valid && spi_ready;
      pending_data = spi_data;
      step();
    end
    applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    step();
    checkReset("reset");
    rst = 1'b0;
`ifdef SPI_SCHED_AVG_EN
    runAverage();
`else
    runTable();
    runLatency();
    runOverflow();
    runTimeout();
    runAsyncReset();
    runRandom();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spi_sample_sched.md
SPI_SAMPLE_SCHED -- requirements
Module: spi_sample_sched

Interface
REQ-001 Parameter PERIOD_W, default 16, width of the sample-interval counter.
REQ-002 Parameter FIFO_DEPTH, default 8 (power of 2), sample FIFO entries.
REQ-003 Parameter TIMEOUT, default 1023, maximum cycles spi_valid is held waiting for spi_ready.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  high = periodic sampling runs.
REQ-007 period  in  PERIOD_W  cycles from capture to next request; value 0 treated as 1.
REQ-008 spi_valid  out  1  transaction request to the SPI sensor reader.
REQ-009 spi_ready  in  1  level; high = byte on spi_data is complete.
REQ-010 spi_data  in  8  received sensor byte.
REQ-011 rd_en  in  1  pop request from the consumer.
REQ-012 rd_data  out  8  popped sample, valid the cycle after an accepted pop.
REQ-013 empty, full  out  1 each  FIFO status.
REQ-014 level  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 clr_err  in  1  one-cycle pulse clearing sticky error flags.
REQ-016 overflow, timeout_err  out  1 each  sticky error flags.

Function
REQ-017 FSM states: IDLE, WAIT, REQUEST, DRAIN.
REQ-018 IDLE -> WAIT when enable=1; the wait counter loads max(period,1).
REQ-019 WAIT: counter decrements each cycle; at 1 -> REQUEST; enable=0 -> IDLE.
REQ-020 spi_valid shall be high exactly while in REQUEST (registered output).
REQ-021 REQUEST: the first cycle with spi_ready=1 captures spi_data and moves to DRAIN; enable=0 does not abort REQUEST.
REQ-022 REQUEST: after TIMEOUT cycles without spi_ready -> DRAIN, no capture, timeout_err set.
REQ-023 DRAIN: wait for spi_ready=0, then -> WAIT (counter reloaded) if enable=1, else IDLE.
REQ-024 Capture-to-next-spi_valid rising edge latency equals max(period,1)+1 cycles when spi_ready drops in the capture+1 cycle.
REQ-025 A captured sample pushes to the FIFO in the cycle after capture.
REQ-026 Push while full and rd_en=0: sample dropped, overflow set.
REQ-027 Push and pop in the same cycle while full: both succeed; overflow not set; level unchanged.
REQ-028 rd_en while empty is ignored; rd_data holds its previous value.
REQ-029 FIFO pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH.
REQ-030 clr_err clears overflow and timeout_err; a set event in the same cycle wins.

Reset
REQ-031 rst asserted (any time, including mid-REQUEST): state IDLE, spi_valid=0, FIFO emptied (empty=1, full=0, level=0), rd_data=0x00, overflow=0, timeout_err=0, counters and accumulator 0.
REQ-032 After rst deasserts, the first spi_valid shall rise no earlier than max(period,1)+1 cycles after enable is sampled high.

Configuration
REQ-033 Macro SPI_SCHED_AVG_EN defined: captures accumulate in a 10-bit sum; every 4th capture pushes sum[9:2] (truncating) and clears the sum; timeouts do not count toward the 4 captures; rst and enable=0 in IDLE clear the partial sum.
REQ-034 Macro SPI_SCHED_AVG_EN undefined: every capture pushes spi_data unchanged; no accumulator logic is present.

Verification
REQ-035 period=20, enable=1, sensor model returns 0x50 on each transaction -> spi_valid pulses every transaction, rd_data=0x50 after each pop, level increments 0->1->2.
REQ-036 No pops, 9 captures with FIFO_DEPTH=8 -> full=1, level=8, overflow=1; clr_err -> overflow=0, full stays 1.
REQ-037 spi_ready held low -> spi_valid high for exactly 1023 cycles, then low, timeout_err=1, level unchanged.
REQ-038 rst pulsed while spi_valid=1 -> spi_valid=0 immediately (asynchronous), empty=1, state IDLE.
REQ-039 Full FIFO, rd_en asserted in the capture-push cycle -> oldest sample out, newest stored, level=8, overflow=0.
REQ-040 SPI_SCHED_AVG_EN defined, samples 0x10,0x20,0x30,0x41 -> single push of 0x28; level=1 only after the 4th capture.
